fetch_pc: RTL
=============

FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter RESET_VECTOR, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter PC_INC, default 2, sequential PC increment in bytes.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 stall  input  1  downstream stall; when 1, no instruction handshake completes.
REQ-006 branch_taken  input  1  redirect request; the select of the downstream next-PC 2-way mux.
REQ-007 branch_target  input  16  redirect address, valid when branch_taken=1.
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  16  read address; equals pc.
REQ-010 imem_ack  input  1  memory read complete; imem_data valid this cycle.
REQ-011 imem_data  input  16  instruction word from memory.
REQ-012 instr  output  16  fetched instruction, registered.
REQ-013 instr_valid  output  1  instr holds a valid instruction.
REQ-014 instr_ready  input  1  downstream accepts instr this cycle.
REQ-015 pc  output  16  address of the current fetch.

Function
REQ-016 FSM states are S_IDLE, S_REQ and S_HOLD; S_IDLE moves to S_REQ unconditionally one cycle after reset release.
REQ-017 In S_REQ, imem_req=1 and imem_addr=pc; on imem_ack=1 with no redirect pending, instr<=imem_data, instr_valid<=1, next state S_HOLD (latency ack->instr_valid is 1 cycle).
REQ-018 In S_HOLD, imem_req=0, and instr and instr_valid are held stable until handshake (instr_valid & instr_ready & ~stall).
REQ-019 On handshake: pc<=branch_taken ? branch_target : pc+PC_INC; instr_valid<=0; next state S_REQ.
REQ-020 branch_taken=1 in S_REQ without imem_ack latches branch_target into a redirect register and sets redirect_pending.
REQ-021 In S_REQ, imem_ack with redirect_pending=1, or imem_ack together with branch_taken=1, discards imem_data, loads pc with the redirect target (live branch_target takes priority), clears redirect_pending, and remains in S_REQ.
REQ-022 branch_taken in S_HOLD without a handshake is ignored.
REQ-023 pc+PC_INC wraps modulo 2^16 (16'hFFFE+2 -> 16'h0000).
REQ-024 stall=1 masks instr_ready; the FSM state, pc and instr stay unchanged.

Reset
REQ-025 While reset=0: pc=RESET_VECTOR, instr=16'h0000, instr_valid=0, imem_req=0, redirect_pending=0, align_err=0 (when present), state=S_IDLE.
REQ-026 Reset asserted mid-transaction abandons the request immediately; a late imem_ack after reset release and before S_REQ is ignored.

Configuration
REQ-027 With macro FETCH_ALIGN_CHECK_EN defined, the block adds output align_err (1 bit); a redirect to an odd branch_target sets align_err=1 (sticky until reset), and the redirect still occurs with bit 0 forced to 0.
REQ-028 Without FETCH_ALIGN_CHECK_EN, port align_err does not exist and branch_target is used unmodified.

Verification
REQ-029 Release reset, imem_ack after 2 cycles with data 16'h1234, instr_ready=1 -> imem_addr=16'h0000, instr=16'h1234 and instr_valid one cycle after ack, then pc=16'h0002.
REQ-030 Hold instr_valid with stall=1 for 5 cycles, then stall=0 -> instr is stable throughout, pc advances exactly once.
REQ-031 Handshake with branch_taken=1 and branch_target=16'h0040 -> next imem_addr=16'h0040.
REQ-032 In S_REQ, pulse branch_taken with target 16'h0100, then ack data 16'hDEAD -> instr_valid stays 0, re-request at 16'h0100.
REQ-033 pc=16'hFFFE, sequential handshake -> pc=16'h0000; with FETCH_ALIGN_CHECK_EN, redirect to 16'h0011 -> align_err=1, pc=16'h0010.
REQ-034 Assert reset while in S_HOLD -> all outputs return to the REQ-025 values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pc.sv
// -----------------------------------------------------------------------------
// fetch_pc -- instruction fetch program counter and fetch sequencer.
//
// Issues one instruction-memory read at a time from the address held in pc,
// captures the returned word into a registered instr/instr_valid pair, and
// advances pc when the downstream stage takes the instruction. The next pc is
// either pc + PC_INC (wrapping modulo 2^16) or the branch target presented
// with the handshake. A branch that arrives while a read is outstanding is
// remembered and applied when that read returns; the returned word is then
// discarded and the fetch is reissued at the target.
//
// Parameters:
//   RESET_VECTOR  pc value loaded on reset
//   PC_INC        sequential pc increment in bytes
//
// Ports:
//   clk            in   sole clock, rising edge
//   reset          in   asynchronous reset, active low
//   stall          in   downstream stall, blocks the instr handshake
//   branch_taken   in   redirect request (next-pc mux select)
//   branch_target  in   redirect address, valid with branch_taken
//   imem_req       out  instruction-memory read request
//   imem_addr      out  read address (equals pc)
//   imem_ack       in   read complete, imem_data valid this cycle
//   imem_data      in   instruction word from memory
//   instr          out  fetched instruction (registered)
//   instr_valid    out  instr holds a valid instruction
//   instr_ready    in   downstream accepts instr this cycle
//   pc             out  address of the current fetch
//   align_err      out  sticky odd-redirect flag (FETCH_ALIGN_CHECK_EN only)
//
// Build option:
//   FETCH_ALIGN_CHECK_EN  when defined, adds align_err; odd redirect targets
//                         set align_err and are used with bit 0 cleared.
// -----------------------------------------------------------------------------
module fetch_pc #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          PC_INC       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_reg;
  logic        redirect_pending_reg;
  logic [15:0] redirect_target_reg;

  logic [15:0] target_fixed;
  logic [15:0] pc_seq;
  logic        handshake;
  logic        redirect_accept;

  // Effective redirect address. With the alignment check enabled bit 0 is
  // dropped so the fetch stays halfword aligned.
`ifdef FETCH_ALIGN_CHECK_EN
  assign target_fixed = {branch_target[15:1], 1'b0};
`else
  assign target_fixed = branch_target;
`endif

  // 16-bit addition wraps naturally at the top of the address space.
  assign pc_seq = pc + 16'(PC_INC);

  // Only S_HOLD can complete a handshake; instr_valid is always set there.
  assign handshake = (state_reg == S_HOLD) && instr_valid && instr_ready && !stall;

  // A live branch_taken is consumed either by a handshake in S_HOLD or by any
  // cycle in S_REQ (latched, or applied together with an ack). In S_HOLD
  // without a handshake it is ignored.
  assign redirect_accept = branch_taken &&
                           ((state_reg == S_REQ) || handshake);

  // State-decoded outputs: state is reset asynchronously, so these drop to
  // their idle values as soon as reset is asserted.
  assign imem_req  = (state_reg == S_REQ);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg            <= S_IDLE;
      pc                   <= RESET_VECTOR;
      instr                <= 16'h0000;
      instr_valid          <= 1'b0;
      redirect_pending_reg <= 1'b0;
      redirect_target_reg  <= 16'h0000;
    end else begin
      case (state_reg)
        // One settling cycle after reset release; a stray ack here is
        // left over from a request abandoned by reset and is ignored.
        S_IDLE: begin
          state_reg <= S_REQ;
        end

        S_REQ: begin
          if (imem_ack) begin
            if (branch_taken) begin
              // Live target wins over any previously latched one.
              pc                   <= target_fixed;
              redirect_pending_reg <= 1'b0;
            end else if (redirect_pending_reg) begin
              pc                   <= redirect_target_reg;
              redirect_pending_reg <= 1'b0;
            end else begin
              instr       <= imem_data;
              instr_valid <= 1'b1;
              state_reg   <= S_HOLD;
            end
          end else if (branch_taken) begin
            // Read still outstanding: remember the target, apply on ack.
            redirect_target_reg  <= target_fixed;
            redirect_pending_reg <= 1'b1;
          end
        end

        S_HOLD: begin
          if (handshake) begin
            pc          <= branch_taken ? target_fixed : pc_seq;
            instr_valid <= 1'b0;
            state_reg   <= S_REQ;
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky until reset; flagged when an odd target is actually accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      align_err <= 1'b0;
    end else if (redirect_accept && branch_target[0]) begin
      align_err <= 1'b1;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = redirect_accept;
`endif

endmodule
